multi_edge_debouncer: RTL and testbench

Parametrised multi-channel input conditioner for push-buttons, switches and robot-side status lines. Each channel has:
- a synchroniser,
- an enable-gated debounce filter,
- edge detection with a per-channel edge mode,
- a sticky pending flag and an overrun flag that firmware or the game FSM clears.

It sits between raw board inputs and the control/game logic, and replaces the per-signal single-bit edge detectors.

---
 rtl/edge_pkg.sv | 39 +++
 rtl/debounce_ch.sv | 75 +++++++
 rtl/multi_edge_debouncer.sv | 108 ++++++++++
 tb/tb_multi_edge_debouncer.sv | 304 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared definitions for the multi-channel edge debouncer.
// Contents:
//   EDGE_*        2-bit per-channel edge mode encodings
//   cnt_width     debounce counter width, never narrower than 1 bit
//   edge_qualify  decides whether a level change is a reportable event
package edge_pkg;

  localparam logic [1:0] EDGE_NONE    = 2'b00;
  localparam logic [1:0] EDGE_ASSERT  = 2'b01;
  localparam logic [1:0] EDGE_RELEASE = 2'b10;
  localparam logic [1:0] EDGE_BOTH    = 2'b11;

  function automatic int cnt_width(input int deb_cycles);
    int w;
    w = $clog2(deb_cycles);
    return (w < 1) ? 1 : w;
  endfunction

  // An assert edge leaves the idle level and a release edge returns to it.
  function automatic logic edge_qualify(input logic [1:0] mode,
                                        input logic       level,
                                        input logic       level_d,
                                        input logic       idle);
    logic assert_s;
    logic release_s;
    logic result_s;
    assert_s  = (level != idle) && (level_d == idle);
    release_s = (level == idle) && (level_d != idle);
    case (mode)
      EDGE_NONE:    result_s = 1'b0;
      EDGE_ASSERT:  result_s = assert_s;
      EDGE_RELEASE: result_s = release_s;
      EDGE_BOTH:    result_s = assert_s | release_s;
      default:      result_s = 1'b0;
    endcase
    return result_s;
  endfunction

endpackage

// File: rtl/debounce_ch.sv
// One input channel: synchroniser, enable-gated debounce counter,
// debounced level and its one-clock-delayed copy.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   enable      debounce tick qualifier
//   din         raw asynchronous input
//   level       debounced level
//   level_d     level delayed by one clk (for edge detection)
module debounce_ch
  import edge_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter bit IDLE_LEVEL  = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic enable,
  input  logic din,
  output logic level,
  output logic level_d
);

  localparam int CW = cnt_width(DEB_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_r;
  logic [CW-1:0]          cnt_r;
  logic [CW-1:0]          cnt_nxt_s;
  logic                   level_r;
  logic                   level_nxt_s;
  logic                   level_d_r;
  logic                   sync_q_s;

  assign sync_q_s = sync_r[SYNC_STAGES-1];
  assign level    = level_r;
  assign level_d  = level_d_r;

  // Debounce counter: any agreement with level restarts the count; only
  // enable ticks advance it, and the final tick commits the new level.
  always_comb begin
    cnt_nxt_s   = cnt_r;
    level_nxt_s = level_r;
    if (sync_q_s == level_r) begin
      cnt_nxt_s = {CW{1'b0}};
    end else if (enable) begin
      if (cnt_r == CNT_MAX) begin
        level_nxt_s = sync_q_s;
        cnt_nxt_s   = {CW{1'b0}};
      end else begin
        cnt_nxt_s = cnt_r + CW'(1);
      end
    end else begin
      cnt_nxt_s   = cnt_r;
      level_nxt_s = level_r;
    end
  end

  // Synchroniser, counter, level and delayed level; level and level_d reset
  // to the same value so reset exit never looks like an edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_r    <= {SYNC_STAGES{IDLE_LEVEL}};
      cnt_r     <= {CW{1'b0}};
      level_r   <= IDLE_LEVEL;
      level_d_r <= IDLE_LEVEL;
    end else begin
      sync_r    <= {sync_r[SYNC_STAGES-2:0], din};
      cnt_r     <= cnt_nxt_s;
      level_r   <= level_nxt_s;
      level_d_r <= level_r;
    end
  end

endmodule

// File: rtl/multi_edge_debouncer.sv
// Multi-channel input conditioner: per-channel debounce, mode-qualified
// edge pulse, sticky pending flag and overrun flag with per-channel clear.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   enable         debounce tick qualifier
//   data_in        raw asynchronous inputs
//   mode           per-channel edge mode, bits [2i+1:2i]
//   clr            per-channel clear of pending_o/overrun_o
//   level_o        debounced levels
//   pulse_o        one-clk event pulse (combinational from level/level_d/mode)
//   pending_o      sticky event flags
//   overrun_o      sticky: event arrived while pending already set
//   any_pending_o  OR of pending_o
module multi_edge_debouncer
  import edge_pkg::*;
#(
  parameter int N_CH        = 4,
  parameter int SYNC_STAGES = 2,
  parameter int DEB_CYCLES  = 4,
  parameter bit IDLE_LEVEL  = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              enable,
  input  logic [N_CH-1:0]   data_in,
  input  logic [2*N_CH-1:0] mode,
  input  logic [N_CH-1:0]   clr,
  output logic [N_CH-1:0]   level_o,
  output logic [N_CH-1:0]   pulse_o,
  output logic [N_CH-1:0]   pending_o,
  output logic [N_CH-1:0]   overrun_o,
  output logic              any_pending_o
);

  logic [N_CH-1:0] level_s;
  logic [N_CH-1:0] level_d_s;
  logic [N_CH-1:0] pulse_s;
  logic [N_CH-1:0] pending_r;
  logic [N_CH-1:0] overrun_r;
  logic [N_CH-1:0] pending_nxt_s;
  logic [N_CH-1:0] overrun_nxt_s;

  for (genvar g = 0; g < N_CH; g++) begin : g_ch
    debounce_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .DEB_CYCLES  (DEB_CYCLES),
      .IDLE_LEVEL  (IDLE_LEVEL)
    ) u_ch (
      .clk     (clk),
      .rst_n   (rst_n),
      .enable  (enable),
      .din     (data_in[g]),
      .level   (level_s[g]),
      .level_d (level_d_s[g])
    );
  end

  // Mode qualification is combinational so a mode change acts immediately.
  always_comb begin
    pulse_s = {N_CH{1'b0}};
    for (int i = 0; i < N_CH; i++) begin
      pulse_s[i] = edge_qualify(mode[2*i +: 2], level_s[i], level_d_s[i], IDLE_LEVEL);
    end
  end

  // Flag update: a pulse always lands in pending; a simultaneous clear only
  // wins over the overrun flag.
  always_comb begin
    pending_nxt_s = pending_r;
    overrun_nxt_s = overrun_r;
    for (int i = 0; i < N_CH; i++) begin
      if (pulse_s[i]) begin
        pending_nxt_s[i] = 1'b1;
        if (clr[i]) begin
          overrun_nxt_s[i] = 1'b0;
        end else if (pending_r[i]) begin
          overrun_nxt_s[i] = 1'b1;
        end else begin
          overrun_nxt_s[i] = overrun_r[i];
        end
      end else if (clr[i]) begin
        pending_nxt_s[i] = 1'b0;
        overrun_nxt_s[i] = 1'b0;
      end else begin
        pending_nxt_s[i] = pending_r[i];
        overrun_nxt_s[i] = overrun_r[i];
      end
    end
  end

  // Sticky flag registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_r <= {N_CH{1'b0}};
      overrun_r <= {N_CH{1'b0}};
    end else begin
      pending_r <= pending_nxt_s;
      overrun_r <= overrun_nxt_s;
    end
  end

  assign level_o       = level_s;
  assign pulse_o       = pulse_s;
  assign pending_o     = pending_r;
  assign overrun_o     = overrun_r;
  assign any_pending_o = |pending_r;

endmodule

// File: tb/tb_multi_edge_debouncer.sv
// Self-checking bench for multi_edge_debouncer (default parameters).
// Expected pulses are queued as {cycle, channel} when stimulus is driven and
// matched by a monitor whenever the DUT raises pulse_o.
module tb_multi_edge_debouncer;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b1;
  logic [3:0] data_in = 4'hF;
  logic [7:0] mode = 8'hFF;
  logic [3:0] clr = 4'h0;
  logic [3:0] level_o;
  logic [3:0] pulse_o;
  logic [3:0] pending_o;
  logic [3:0] overrun_o;
  logic       any_pending_o;

  typedef struct {
    int cyc;
    int ch;
  } ev_t;

  ev_t exp_q[$];
  int  cyc = 0;
  int  n_total = 0;
  int  n_pass = 0;
  bit  en_strobe = 1'b0;
  int  ph = 0;

  multi_edge_debouncer dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .enable        (enable),
    .data_in       (data_in),
    .mode          (mode),
    .clr           (clr),
    .level_o       (level_o),
    .pulse_o       (pulse_o),
    .pending_o     (pending_o),
    .overrun_o     (overrun_o),
    .any_pending_o (any_pending_o)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor: every observed pulse must match the queue head.
  always @(negedge clk) begin
    if (rst_n) begin
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
        n_total++;
        $display("FAIL missed_pulse: ch=%0d expected at cycle %0d, not observed (now %0d)",
                 exp_q[0].ch, exp_q[0].cyc, cyc);
        void'(exp_q.pop_front());
      end
      for (int ch = 0; ch < 4; ch++) begin
        if (pulse_o[ch]) begin
          n_total++;
          if (exp_q.size() == 0) begin
            $display("FAIL unexpected_pulse: ch=%0d at cycle %0d, none expected", ch, cyc);
          end else begin
            ev_t e;
            e = exp_q.pop_front();
            if (e.cyc !== cyc || e.ch !== ch) begin
              $display("FAIL pulse_match: got ch=%0d cycle=%0d, expected ch=%0d cycle=%0d",
                       ch, cyc, e.ch, e.cyc);
            end else begin
              n_pass++;
            end
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    if (en_strobe) begin
      ph++;
      enable = ((ph % 4) == 0);
    end else begin
      enable = 1'b1;
    end
    @(negedge clk);
  endtask

  task automatic expect_pulse(input int ch);
    ev_t e;
    e.cyc = cyc + 6;
    e.ch  = ch;
    exp_q.push_back(e);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    data_in = 4'hF;
    repeat (3) @(negedge clk);
    n_total++;
    if ({level_o, pulse_o, pending_o, overrun_o, any_pending_o} !== {4'hF, 4'h0, 4'h0, 4'h0, 1'b0})
      $display("FAIL reset_state: level=%h pulse=%h pend=%h ovr=%h any=%b",
               level_o, pulse_o, pending_o, overrun_o, any_pending_o);
    else n_pass++;
    rst_n = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      n_total++;
      if (level_o !== 4'hF || {pulse_o, pending_o, overrun_o} !== 12'h000)
        $display("FAIL idle_after_reset: cycle %0d level=%h pulse=%h pend=%h ovr=%h (want F/0/0/0)",
                 i, level_o, pulse_o, pending_o, overrun_o);
      else n_pass++;
    end
  endtask

  task automatic test_clean_press();
    data_in[0] = 1'b0;
    expect_pulse(0);
    repeat (5) step();
    n_total++;
    if (level_o[0] !== 1'b1) $display("FAIL press_early: level_o[0]=%b want 1 at edge 5", level_o[0]);
    else n_pass++;
    step();
    n_total++;
    if (level_o[0] !== 1'b0 || pulse_o[0] !== 1'b1)
      $display("FAIL press_edge6: level_o[0]=%b pulse_o[0]=%b want 0/1", level_o[0], pulse_o[0]);
    else n_pass++;
    step();
    n_total++;
    if (pending_o[0] !== 1'b1 || any_pending_o !== 1'b1 || pulse_o[0] !== 1'b0)
      $display("FAIL press_edge7: pend=%b any=%b pulse=%b want 1/1/0",
               pending_o[0], any_pending_o, pulse_o[0]);
    else n_pass++;
    data_in[0] = 1'b1;
    expect_pulse(0);
    repeat (8) step();
    n_total++;
    if (level_o[0] !== 1'b1 || overrun_o[0] !== 1'b1)
      $display("FAIL release_ch0: level=%b ovr=%b want 1/1", level_o[0], overrun_o[0]);
    else n_pass++;
    clr[0] = 1'b1;
    step();
    clr[0] = 1'b0;
    n_total++;
    if (pending_o[0] !== 1'b0 || overrun_o[0] !== 1'b0 || any_pending_o !== 1'b0)
      $display("FAIL clear_ch0: pend=%b ovr=%b any=%b want 0/0/0",
               pending_o[0], overrun_o[0], any_pending_o);
    else n_pass++;
  endtask

  task automatic test_glitch();
    data_in[1] = 1'b0;
    repeat (3) step();
    data_in[1] = 1'b1;
    repeat (10) step();
    n_total++;
    if (level_o[1] !== 1'b1 || pending_o[1] !== 1'b0)
      $display("FAIL glitch_short: level=%b pend=%b want 1/0", level_o[1], pending_o[1]);
    else n_pass++;
    en_strobe = 1'b1;
    ph = 0;
    data_in[1] = 1'b0;
    repeat (8) step();
    n_total++;
    if (level_o[1] !== 1'b1) $display("FAIL strobe_freeze: level_o[1]=%b want 1", level_o[1]);
    else n_pass++;
    repeat (4) step();
    data_in[1] = 1'b1;
    repeat (10) step();
    n_total++;
    if (level_o[1] !== 1'b1 || pending_o[1] !== 1'b0)
      $display("FAIL strobe_glitch: level=%b pend=%b want 1/0", level_o[1], pending_o[1]);
    else n_pass++;
    en_strobe = 1'b0;
    enable = 1'b1;
    step();
  endtask

  task automatic test_mode();
    mode[5:4] = 2'b01;
    data_in[2] = 1'b0;
    expect_pulse(2);
    repeat (10) step();
    data_in[2] = 1'b1;
    repeat (10) step();
    n_total++;
    if (pending_o[2] !== 1'b1 || overrun_o[2] !== 1'b0 || level_o[2] !== 1'b1)
      $display("FAIL mode_assert: pend=%b ovr=%b level=%b want 1/0/1",
               pending_o[2], overrun_o[2], level_o[2]);
    else n_pass++;
    clr[2] = 1'b1;
    step();
    clr[2] = 1'b0;
    mode[5:4] = 2'b10;
    data_in[2] = 1'b0;
    repeat (10) step();
    n_total++;
    if (pending_o[2] !== 1'b0) $display("FAIL mode_release_press: pend=%b want 0", pending_o[2]);
    else n_pass++;
    data_in[2] = 1'b1;
    expect_pulse(2);
    repeat (10) step();
    n_total++;
    if (pending_o[2] !== 1'b1) $display("FAIL mode_release: pend=%b want 1", pending_o[2]);
    else n_pass++;
    clr[2] = 1'b1;
    step();
    clr[2] = 1'b0;
    mode[5:4] = 2'b00;
    data_in[2] = 1'b0;
    repeat (10) step();
    data_in[2] = 1'b1;
    repeat (10) step();
    n_total++;
    if (pending_o[2] !== 1'b0) $display("FAIL mode_none: pend=%b want 0", pending_o[2]);
    else n_pass++;
    mode[5:4] = 2'b11;
  endtask

  task automatic test_overrun();
    data_in[3] = 1'b0;
    expect_pulse(3);
    repeat (10) step();
    data_in[3] = 1'b1;
    expect_pulse(3);
    repeat (10) step();
    data_in[3] = 1'b0;
    expect_pulse(3);
    repeat (10) step();
    n_total++;
    if (pending_o[3] !== 1'b1 || overrun_o[3] !== 1'b1)
      $display("FAIL overrun_set: pend=%b ovr=%b want 1/1", pending_o[3], overrun_o[3]);
    else n_pass++;
    clr[3] = 1'b1;
    step();
    clr[3] = 1'b0;
    n_total++;
    if (pending_o[3] !== 1'b0 || overrun_o[3] !== 1'b0)
      $display("FAIL overrun_clr: pend=%b ovr=%b want 0/0", pending_o[3], overrun_o[3]);
    else n_pass++;
    data_in[3] = 1'b1;
    expect_pulse(3);
    repeat (10) step();
    data_in[3] = 1'b0;
    expect_pulse(3);
    repeat (6) step();
    clr[3] = 1'b1;
    step();
    clr[3] = 1'b0;
    n_total++;
    if (pending_o[3] !== 1'b1 || overrun_o[3] !== 1'b0)
      $display("FAIL clr_with_pulse: pend=%b ovr=%b want 1/0", pending_o[3], overrun_o[3]);
    else n_pass++;
    data_in[3] = 1'b1;
    expect_pulse(3);
    repeat (10) step();
  endtask

  task automatic test_reset_mid();
    data_in[1] = 1'b0;
    repeat (4) step();
    rst_n = 1'b0;
    #1;
    n_total++;
    if ({level_o, pulse_o, pending_o, overrun_o, any_pending_o} !== {4'hF, 4'h0, 4'h0, 4'h0, 1'b0})
      $display("FAIL mid_reset_state: level=%h pulse=%h pend=%h ovr=%h any=%b",
               level_o, pulse_o, pending_o, overrun_o, any_pending_o);
    else n_pass++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    expect_pulse(1);
    repeat (5) step();
    n_total++;
    if (level_o[1] !== 1'b1) $display("FAIL mid_reset_early: level_o[1]=%b want 1", level_o[1]);
    else n_pass++;
    step();
    n_total++;
    if (level_o[1] !== 1'b0) $display("FAIL mid_reset_edge6: level_o[1]=%b want 0", level_o[1]);
    else n_pass++;
    step();
    n_total++;
    if (pending_o !== 4'b0010) $display("FAIL mid_reset_pending: pend=%b want 0010", pending_o);
    else n_pass++;
    data_in[1] = 1'b1;
    expect_pulse(1);
    repeat (10) step();
  endtask

  initial begin
    test_reset();
    test_clean_press();
    test_glitch();
    test_mode();
    test_overrun();
    test_reset_mid();
    repeat (5) step();
    n_total++;
    if (exp_q.size() != 0) $display("FAIL drain: %0d expected pulses never seen", exp_q.size());
    else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
